// File: rtl/frame_sched.sv
// Frame scheduler: clears the framebuffer to a background colour, then hands the
// framebuffer write port to the gpu until the shared command FIFO drains.
`timescale 1ns/1ps
module frame_sched #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [5:0]    bg_color,
  input  logic          fifo_empty,
  output logic          gpu_start,
  input  logic          gpu_done,
  input  logic [AW-1:0] gpu_addr,
  input  logic          gpu_wen,
  input  logic [5:0]    gpu_dout,
  output logic [AW-1:0] fb_addr,
  output logic          fb_wen,
  output logic [5:0]    fb_dout,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, FDONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] counter_q, counter_d;
  logic [5:0]    color_q, color_d;
  logic          gpu_start_q, gpu_start_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic          fb_wen_q, fb_wen_d;
  logic [5:0]    fb_dout_q, fb_dout_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          gpu_owns_q, gpu_owns_d;

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    color_d       = color_q;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = CLEAR;
          counter_d = '0;
          color_d   = bg_color;
        end
      end
      CLEAR: begin
        if (counter_q == LAST_ADDR) begin
          counter_d = '0;
          state_d   = fifo_empty ? FDONE : START;
        end else begin
          counter_d = counter_q + AW'(1);
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (gpu_done) state_d = fifo_empty ? FDONE : START;
      end
      FDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    if (state_d == FDONE) frame_count_d = frame_count_q + 16'd1;
    gpu_start_d  = (state_d == START);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == FDONE);

    gpu_owns_q   = (state_q == START) || (state_q == WAIT);
    gpu_owns_d   = (state_d == START) || (state_d == WAIT);

    fb_wen_d  = 1'b0;
    fb_addr_d = '0;
    fb_dout_d = '0;
    if (state_d == CLEAR) begin
      fb_wen_d  = 1'b1;
      fb_addr_d = counter_d;
      fb_dout_d = color_d;
    end else if (gpu_owns_q && gpu_owns_d) begin
      fb_wen_d  = gpu_wen;
      fb_addr_d = gpu_addr;
      fb_dout_d = gpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      color_q       <= '0;
      gpu_start_q   <= 1'b0;
      fb_addr_q     <= '0;
      fb_wen_q      <= 1'b0;
      fb_dout_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      color_q       <= color_d;
      gpu_start_q   <= gpu_start_d;
      fb_addr_q     <= fb_addr_d;
      fb_wen_q      <= fb_wen_d;
      fb_dout_q     <= fb_dout_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign gpu_start   = gpu_start_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wen      = fb_wen_q;
  assign fb_dout     = fb_dout_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_sched.sv
// Directed self-checking bench for frame_sched with a tiny 4x2 framebuffer.
`timescale 1ns/1ps
module tb_frame_sched;

  localparam int H_RES = 4;
  localparam int V_RES = 2;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [5:0]    bg_color;
  logic          fifo_empty;
  logic          gpu_start;
  logic          gpu_done;
  logic [AW-1:0] gpu_addr;
  logic          gpu_wen;
  logic [5:0]    gpu_dout;
  logic [AW-1:0] fb_addr;
  logic          fb_wen;
  logic [5:0]    fb_dout;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;

  int checks = 0;
  int failures = 0;
  int gpu_start_pulses = 0;
  int pulses_before;

  frame_sched #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bg_color(bg_color),
    .fifo_empty(fifo_empty), .gpu_start(gpu_start), .gpu_done(gpu_done),
    .gpu_addr(gpu_addr), .gpu_wen(gpu_wen), .gpu_dout(gpu_dout),
    .fb_addr(fb_addr), .fb_wen(fb_wen), .fb_dout(fb_dout), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (gpu_start) gpu_start_pulses++;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic [5:0] bg, input logic fe);
    frame_start = fs;
    bg_color    = bg;
    fifo_empty  = fe;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; bg_color = '0; fifo_empty = 1'b1;
    gpu_done = 1'b0; gpu_addr = '0; gpu_wen = 1'b0; gpu_dout = '0;
    tick(2);
    reset = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fb_wen", fb_wen, 0);
    checkOutput("rst_fb_addr", fb_addr, 0);
    checkOutput("rst_fb_dout", fb_dout, 0);
    checkOutput("rst_gpu_start", gpu_start, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_count", frame_count, 0);

    // gpu writes while idle are dropped
    gpu_wen = 1'b1; gpu_addr = 3'd5; gpu_dout = 6'h15;
    tick(2);
    checkOutput("idle_gpu_wen_dropped", fb_wen, 0);

    // Clear-only frame, gpu writes kept active to prove they are ignored during CLEAR
    applyStimulus(1'b1, 6'b110000, 1'b1);
    tick();
    applyStimulus(1'b0, 6'b000000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("a_wen%0d", i), fb_wen, 1);
      checkOutput($sformatf("a_addr%0d", i), fb_addr, i);
      checkOutput($sformatf("a_dout%0d", i), fb_dout, 6'h30);
      checkOutput($sformatf("a_gpu_start%0d", i), gpu_start, 0);
      tick();
    end
    gpu_wen = 1'b0;
    checkOutput("a_frame_done", frame_done, 1);
    checkOutput("a_fdone_wen", fb_wen, 0);
    checkOutput("a_count", frame_count, 1);
    checkOutput("a_fdone_busy", busy, 1);
    tick();
    checkOutput("a_idle_busy", busy, 0);
    checkOutput("a_done_once", frame_done, 0);

    // Clear then one gpu pass; frame_start pulses during CLEAR and WAIT are ignored
    pulses_before = gpu_start_pulses;
    applyStimulus(1'b1, 6'h03, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("b_addr%0d", i), fb_addr, i);
      checkOutput($sformatf("b_dout%0d", i), fb_dout, 6'h03);
      frame_start = (i == 3);
      tick();
    end
    frame_start = 1'b0;
    checkOutput("b_gpu_start", gpu_start, 1);
    checkOutput("b_start_wen", fb_wen, 0);
    tick();
    checkOutput("b_gpu_start_1cyc", gpu_start, 0);
    gpu_wen = 1'b1; gpu_addr = 3'd3; gpu_dout = 6'h3F; frame_start = 1'b1;
    tick();
    checkOutput("b_pass_wen", fb_wen, 1);
    checkOutput("b_pass_addr", fb_addr, 3);
    checkOutput("b_pass_dout", fb_dout, 6'h3F);
    gpu_wen = 1'b0; frame_start = 1'b0; fifo_empty = 1'b1;
    tick();
    checkOutput("b_pass_wen_off", fb_wen, 0);
    checkOutput("b_wait_busy", busy, 1);
    tick(2);
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    checkOutput("b_frame_done", frame_done, 1);
    checkOutput("b_count", frame_count, 2);
    checkOutput("b_one_gpu_start", gpu_start_pulses - pulses_before, 1);
    tick();
    checkOutput("b_idle_busy", busy, 0);
    checkOutput("b_no_requeue", busy, 0);

    // Two gpu passes: FIFO still non-empty at the first gpu_done
    applyStimulus(1'b1, 6'h0C, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 1'b0);
    tick(7);
    checkOutput("c_last_addr", fb_addr, 7);
    checkOutput("c_last_dout", fb_dout, 6'h0C);
    tick();
    checkOutput("c_start1", gpu_start, 1);
    tick();
    gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    checkOutput("c_start2", gpu_start, 1);
    checkOutput("c_no_done_yet", frame_done, 0);
    tick();
    fifo_empty = 1'b1; gpu_done = 1'b1;
    tick();
    gpu_done = 1'b0;
    checkOutput("c_frame_done", frame_done, 1);
    checkOutput("c_count", frame_count, 3);
    tick();

    // Reset in the middle of a clear aborts the frame
    applyStimulus(1'b1, 6'h2A, 1'b1);
    tick();
    applyStimulus(1'b0, 6'h00, 1'b1);
    tick(5);
    checkOutput("d_addr5", fb_addr, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("d_rst_wen", fb_wen, 0);
    checkOutput("d_rst_busy", busy, 0);
    checkOutput("d_rst_count", frame_count, 0);
    tick();
    checkOutput("d_no_done", frame_done, 0);
    applyStimulus(1'b1, 6'h15, 1'b1);
    tick();
    applyStimulus(1'b0, 6'h00, 1'b1);
    checkOutput("d_restart_addr", fb_addr, 0);
    checkOutput("d_restart_dout", fb_dout, 6'h15);
    tick(7);
    checkOutput("d_count_mid", frame_count, 0);
    tick();
    checkOutput("d_frame_done", frame_done, 1);
    checkOutput("d_count", frame_count, 1);
    tick();

    // frame_count wrap: preload near the top, then complete two frames
    force dut.frame_count_q = 16'hFFFE;
    tick();
    release dut.frame_count_q;
    tick();
    checkOutput("e_preload", frame_count, 16'hFFFE);
    for (int f = 0; f < 2; f++) begin
      applyStimulus(1'b1, 6'h01, 1'b1);
      tick();
      applyStimulus(1'b0, 6'h00, 1'b1);
      tick(8);
      checkOutput($sformatf("e_done%0d", f), frame_done, 1);
      checkOutput($sformatf("e_count%0d", f), frame_count, (f == 0) ? 16'hFFFF : 16'h0000);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
